// File: rtl/unidad_busqueda.sv
// Instruction-fetch stage: PC, IF/ID register, stall/branch/halt handling.
// Optional retired-fetch counter enabled by defining UNIDAD_BUSQUEDA_CONTADOR_EN.
module unidad_busqueda #(
  parameter int unsigned            ANCHO_DIR = 8,
  parameter logic [ANCHO_DIR-1:0]   PC_INICIO = '0,
  parameter logic [31:0]            INST_HALT = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 salto_en,
  input  logic [ANCHO_DIR-1:0] salto_dir,
  input  logic [31:0]          inst_mem,
  output logic [ANCHO_DIR-1:0] dir,
  output logic [31:0]          inst_if_id,
  output logic [ANCHO_DIR-1:0] pc4_if_id,
  output logic                 valido,
  output logic                 detenido,
`ifdef UNIDAD_BUSQUEDA_CONTADOR_EN
  output logic [15:0]          cuenta_inst,
`endif
  output logic                 err_alineacion
);

  typedef enum logic [1:0] {
    ARRANQUE = 2'd0,
    BUSQUEDA = 2'd1,
    DETENIDO = 2'd2
  } estado_t;

  estado_t              estado;
  logic [ANCHO_DIR-1:0] pc;
  logic [ANCHO_DIR-1:0] pc_mas4;
  logic [ANCHO_DIR-1:0] objetivo;

  assign dir      = pc;
  assign pc_mas4  = ANCHO_DIR'(pc + ANCHO_DIR'(4));
  assign objetivo = {salto_dir[ANCHO_DIR-1:2], 2'b00};

  // Branch beats stall beats normal fetch; halt word freezes the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado         <= ARRANQUE;
      pc             <= PC_INICIO;
      inst_if_id     <= '0;
      pc4_if_id      <= '0;
      valido         <= 1'b0;
      detenido       <= 1'b0;
      err_alineacion <= 1'b0;
`ifdef UNIDAD_BUSQUEDA_CONTADOR_EN
      cuenta_inst    <= '0;
`endif
    end else begin
      case (estado)
        ARRANQUE: estado <= BUSQUEDA;
        BUSQUEDA: begin
          if (salto_en) begin
            pc         <= objetivo;
            inst_if_id <= '0;
            valido     <= 1'b0;
            if (salto_dir[1:0] != 2'b00) err_alineacion <= 1'b1;
          end else if (!stall) begin
            if (inst_mem == INST_HALT) begin
              inst_if_id <= '0;
              valido     <= 1'b0;
              detenido   <= 1'b1;
              estado     <= DETENIDO;
            end else begin
              inst_if_id <= inst_mem;
              pc4_if_id  <= pc_mas4;
              valido     <= 1'b1;
              pc         <= pc_mas4;
`ifdef UNIDAD_BUSQUEDA_CONTADOR_EN
              if (cuenta_inst != 16'hFFFF) cuenta_inst <= 16'(cuenta_inst + 16'd1);
`endif
            end
          end
        end
        DETENIDO: estado <= DETENIDO;
        default:  estado <= ARRANQUE;
      endcase
    end
  end

endmodule

// File: tb/tb_unidad_busqueda.sv
// Directed bench for unidad_busqueda with a byte-addressed big-endian memory model.
// Counter checks are compiled in when UNIDAD_BUSQUEDA_CONTADOR_EN is defined.
module tb_unidad_busqueda;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        salto_en;
  logic [7:0]  salto_dir;
  logic [31:0] inst_mem;
  logic [7:0]  dir;
  logic [31:0] inst_if_id;
  logic [7:0]  pc4_if_id;
  logic        valido;
  logic        detenido;
  logic        err_alineacion;
`ifdef UNIDAD_BUSQUEDA_CONTADOR_EN
  logic [15:0] cuenta_inst;
`endif

  logic [7:0] mem [256];
  int errores = 0;
  int total   = 0;

  unidad_busqueda dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .salto_en       (salto_en),
    .salto_dir      (salto_dir),
    .inst_mem       (inst_mem),
    .dir            (dir),
    .inst_if_id     (inst_if_id),
    .pc4_if_id      (pc4_if_id),
    .valido         (valido),
    .detenido       (detenido),
`ifdef UNIDAD_BUSQUEDA_CONTADOR_EN
    .cuenta_inst    (cuenta_inst),
`endif
    .err_alineacion (err_alineacion)
  );

  always #5 clk = ~clk;

  assign inst_mem = {mem[dir], mem[8'(dir + 8'd1)], mem[8'(dir + 8'd2)], mem[8'(dir + 8'd3)]};

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      errores++;
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    mem[4] = 8'hAA; mem[5] = 8'hBB; mem[6] = 8'hCC; mem[7] = 8'hDD;
    for (int i = 8; i < 12; i++) mem[i] = 8'hFF;
    mem[252] = 8'h01; mem[253] = 8'h02; mem[254] = 8'h03; mem[255] = 8'h04;

    rst = 1'b1; stall = 1'b0; salto_en = 1'b0; salto_dir = 8'h00;
    tick();
    comprobar("rst_dir",    32'(dir), 32'h00);
    comprobar("rst_inst",   inst_if_id, 32'h0);
    comprobar("rst_pc4",    32'(pc4_if_id), 32'h00);
    comprobar("rst_valido", 32'(valido), 32'h0);
    comprobar("rst_det",    32'(detenido), 32'h0);
    comprobar("rst_err",    32'(err_alineacion), 32'h0);
    rst = 1'b0;

    // ARRANQUE: no capture, inputs ignored
    stall = 1'b1;
    tick();
    comprobar("arr_valido", 32'(valido), 32'h0);
    comprobar("arr_dir",    32'(dir), 32'h00);
    stall = 1'b0;
    tick();
    comprobar("cap1_inst",   inst_if_id, 32'h12345678);
    comprobar("cap1_pc4",    32'(pc4_if_id), 32'h04);
    comprobar("cap1_valido", 32'(valido), 32'h1);
    comprobar("cap1_dir",    32'(dir), 32'h04);

    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      comprobar("stall_dir",    32'(dir), 32'h04);
      comprobar("stall_inst",   inst_if_id, 32'h12345678);
      comprobar("stall_valido", 32'(valido), 32'h1);
    end
    stall = 1'b0;
    tick();
    comprobar("cap2_inst",   inst_if_id, 32'hAABBCCDD);
    comprobar("cap2_pc4",    32'(pc4_if_id), 32'h08);
    comprobar("cap2_valido", 32'(valido), 32'h1);
`ifdef UNIDAD_BUSQUEDA_CONTADOR_EN
    comprobar("cnt_two", 32'(cuenta_inst), 32'd2);
`endif

    tick();
    comprobar("halt_det",    32'(detenido), 32'h1);
    comprobar("halt_valido", 32'(valido), 32'h0);
    comprobar("halt_inst",   inst_if_id, 32'h0);
    comprobar("halt_dir",    32'(dir), 32'h08);
    salto_en = 1'b1; salto_dir = 8'h20; stall = 1'b1;
    tick();
    tick();
    comprobar("halt_salto_dir", 32'(dir), 32'h08);
    comprobar("halt_salto_det", 32'(detenido), 32'h1);
    comprobar("halt_salto_val", 32'(valido), 32'h0);
`ifdef UNIDAD_BUSQUEDA_CONTADOR_EN
    comprobar("cnt_halt", 32'(cuenta_inst), 32'd2);
`endif
    salto_en = 1'b0; stall = 1'b0;

    // Asynchronous reset out of DETENIDO, checked before any edge
    #2 rst = 1'b1;
    #1;
    comprobar("arst_det", 32'(detenido), 32'h0);
    comprobar("arst_dir", 32'(dir), 32'h00);
`ifdef UNIDAD_BUSQUEDA_CONTADOR_EN
    comprobar("arst_cnt", 32'(cuenta_inst), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    tick();
    comprobar("r2_inst", inst_if_id, 32'h12345678);

    // Misaligned branch together with stall: branch wins, bubble inserted
    salto_en = 1'b1; salto_dir = 8'h06; stall = 1'b1;
    tick();
    comprobar("salto_dir",    32'(dir), 32'h04);
    comprobar("salto_valido", 32'(valido), 32'h0);
    comprobar("salto_inst",   inst_if_id, 32'h0);
    comprobar("salto_pc4",    32'(pc4_if_id), 32'h04);
    comprobar("salto_err",    32'(err_alineacion), 32'h1);
    salto_en = 1'b0; stall = 1'b0;
    tick();
    comprobar("post_inst", inst_if_id, 32'hAABBCCDD);
    comprobar("post_pc4",  32'(pc4_if_id), 32'h08);
    comprobar("post_err",  32'(err_alineacion), 32'h1);

    // Aligned branch to FC, then wrap of pc+4
    salto_en = 1'b1; salto_dir = 8'hFC;
    tick();
    comprobar("fc_dir", 32'(dir), 32'hFC);
    comprobar("fc_pc4", 32'(pc4_if_id), 32'h08);
    salto_en = 1'b0;
    tick();
    comprobar("wrap_inst",   inst_if_id, 32'h01020304);
    comprobar("wrap_pc4",    32'(pc4_if_id), 32'h00);
    comprobar("wrap_dir",    32'(dir), 32'h00);
    comprobar("wrap_valido", 32'(valido), 32'h1);
`ifdef UNIDAD_BUSQUEDA_CONTADOR_EN
    comprobar("cnt_wrap", 32'(cuenta_inst), 32'd3);
`endif

    // Asynchronous reset while valid data is held
    #2 rst = 1'b1;
    #1;
    comprobar("arst2_inst",   inst_if_id, 32'h0);
    comprobar("arst2_valido", 32'(valido), 32'h0);
    comprobar("arst2_pc4",    32'(pc4_if_id), 32'h00);
    comprobar("arst2_err",    32'(err_alineacion), 32'h0);
    comprobar("arst2_dir",    32'(dir), 32'h00);

    $display("Result: errors=%0d of %0d checks", errores, total);
    $finish;
  end

endmodule
